// File: rtl/lane_deskew_buffer.sv
// Multi-lane deskew buffer: measures COM arrival skew, then delays each lane so COMs leave together.
// Optional macro DESKEW_AUTO_REALIGN_EN: misalignment re-enters SEARCH instead of latching LOCK_ERR.

module lane_deskew_buffer #(
   parameter int                    NUM_LANES  = 4,
   parameter int                    DATA_WIDTH = 10,
   parameter int                    MAX_SKEW   = 4,
   parameter logic [DATA_WIDTH-1:0] COM_P      = 10'b0011111010,
   parameter logic [DATA_WIDTH-1:0] COM_N      = 10'b1100000101,
   localparam int                   SKEW_W     = $clog2(MAX_SKEW + 1)
) (
   input  logic                             read_clk,
   input  logic                             rst_n,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]  data_in,
   input  logic                             in_valid,
   output logic [NUM_LANES*DATA_WIDTH-1:0]  data_out,
   output logic                             out_valid,
   output logic                             aligned,
   output logic                             deskew_error,
   output logic [NUM_LANES*SKEW_W-1:0]      lane_skew
);

   typedef enum logic [1:0] {
      ST_SEARCH   = 2'd0,
      ST_ALIGNED  = 2'd1,
      ST_LOCK_ERR = 2'd2
   } state_t;

   state_t state, state_next;

   logic [DATA_WIDTH-1:0] line    [NUM_LANES][MAX_SKEW+1];
   logic [SKEW_W-1:0]     delay   [NUM_LANES];
   logic [SKEW_W-1:0]     arrival [NUM_LANES];
   logic [NUM_LANES-1:0]  recorded;
   logic                  window_open;
   logic [SKEW_W-1:0]     cnt;

   logic [DATA_WIDTH-1:0] sym_in  [NUM_LANES];
   logic [DATA_WIDTH-1:0] sel     [NUM_LANES];
   logic [SKEW_W-1:0]     arr_eff [NUM_LANES];
   logic [NUM_LANES-1:0]  com_in, com_sel, rec_next;
   logic [SKEW_W-1:0]     cur_cnt, max_arr;
   logic                  searching, active, lock_now, timeout, misalign;

   function automatic logic is_com(input logic [DATA_WIDTH-1:0] s);
      return (s == COM_P) || (s == COM_N);
   endfunction

   // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
   always_comb begin : lane_select
      for (int i = 0; i < NUM_LANES; i++) begin
         sym_in[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
         com_in[i] = is_com(sym_in[i]);
         sel[i]    = line[i][0];
         for (int k = 1; k <= MAX_SKEW; k++) begin
            if (delay[i] == SKEW_W'(k)) sel[i] = line[i][k];
         end
         com_sel[i] = is_com(sel[i]);
      end
   end

   // Lanes not yet recorded take the current count, so a lock cycle sees final arrivals.
   always_comb begin : search_calc
      searching = in_valid && (state == ST_SEARCH);
      cur_cnt   = window_open ? cnt : '0;
      active    = searching && (window_open || (|com_in));
      rec_next  = recorded | com_in;
      max_arr   = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         arr_eff[i] = recorded[i] ? arrival[i] : cur_cnt;
         if (arr_eff[i] > max_arr) max_arr = arr_eff[i];
      end
      lock_now = active && (&rec_next);
      timeout  = searching && window_open && (cnt == SKEW_W'(MAX_SKEW)) && !lock_now;
      misalign = in_valid && (state == ST_ALIGNED) && (|com_sel) && !(&com_sel);
   end

   always_comb begin : fsm_next
      state_next = state;
      case (state)
         ST_SEARCH:  if (lock_now) state_next = ST_ALIGNED;
         ST_ALIGNED: begin
            if (misalign) begin
`ifdef DESKEW_AUTO_REALIGN_EN
               state_next = ST_SEARCH;
`else
               state_next = ST_LOCK_ERR;
`endif
            end
         end
         ST_LOCK_ERR: state_next = ST_LOCK_ERR;
         default:     state_next = ST_SEARCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) state <= ST_SEARCH;
      else        state <= state_next;
   end

   // NOTE: the shift lines are cleared on reset so stale symbols can never fake a COM after restart.
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++)
            for (int k = 0; k <= MAX_SKEW; k++) line[i][k] <= '0;
      end else if (in_valid) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            line[i][0] <= sym_in[i];
            for (int k = 1; k <= MAX_SKEW; k++) line[i][k] <= line[i][k-1];
         end
      end
   end

   // A timeout clears the window without re-opening it, even if a COM arrives in that cycle.
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         window_open <= 1'b0;
         cnt         <= '0;
         recorded    <= '0;
         for (int i = 0; i < NUM_LANES; i++) arrival[i] <= '0;
      end else if (searching) begin
         if (lock_now || timeout) begin
            window_open <= 1'b0;
            cnt         <= '0;
            recorded    <= '0;
            for (int i = 0; i < NUM_LANES; i++) arrival[i] <= '0;
         end else if (active) begin
            window_open <= 1'b1;
            recorded    <= rec_next;
            for (int i = 0; i < NUM_LANES; i++) begin
               if (com_in[i] && !recorded[i]) arrival[i] <= cur_cnt;
            end
            cnt <= (cur_cnt == SKEW_W'(MAX_SKEW)) ? cur_cnt : cur_cnt + SKEW_W'(1);
         end
      end
   end

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) delay[i] <= '0;
      end else if (lock_now) begin
         for (int i = 0; i < NUM_LANES; i++) delay[i] <= max_arr - arr_eff[i];
      end
   end

   // The beat that trips the check is never presented as valid.
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out     <= '0;
         out_valid    <= 1'b0;
         deskew_error <= 1'b0;
      end else begin
         if (in_valid) begin
            for (int i = 0; i < NUM_LANES; i++) data_out[i*DATA_WIDTH +: DATA_WIDTH] <= sel[i];
         end
         out_valid    <= in_valid && (state == ST_ALIGNED) && !misalign;
         deskew_error <= timeout || misalign;
      end
   end

   always_comb begin : skew_pack
      lane_skew = '0;
      for (int i = 0; i < NUM_LANES; i++) lane_skew[i*SKEW_W +: SKEW_W] = delay[i];
   end

   assign aligned = (state == ST_ALIGNED);

endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Directed bench for lane_deskew_buffer: table of lock scenarios plus hand-written timeout,
// slip, and async-reset sequences. Lane streams carry periodic COMs at per-lane offsets.

module tb_lane_deskew_buffer;

   localparam int NL     = 4;
   localparam int DW     = 10;
   localparam int SW     = 3;
   localparam int PERIOD = 16;
   localparam logic [DW-1:0] COM_P = 10'b0011111010;
   localparam logic [DW-1:0] COM_N = 10'b1100000101;
   localparam logic [NL*DW-1:0] ALL_COM = {COM_N, COM_P, COM_N, COM_P};

   typedef logic [NL-1:0][SW-1:0] skew_t;

   typedef struct {
      skew_t off;
      int    gap;
      skew_t skew;
   } vec_t;

   logic              read_clk = 1'b0;
   logic              rst_n    = 1'b0;
   logic [NL*DW-1:0]  data_in  = '0;
   logic              in_valid = 1'b0;
   logic [NL*DW-1:0]  data_out;
   logic              out_valid;
   logic              aligned;
   logic              deskew_error;
   logic [NL*SW-1:0]  lane_skew;

   lane_deskew_buffer dut (
      .read_clk     (read_clk),
      .rst_n        (rst_n),
      .data_in      (data_in),
      .in_valid     (in_valid),
      .data_out     (data_out),
      .out_valid    (out_valid),
      .aligned      (aligned),
      .deskew_error (deskew_error),
      .lane_skew    (lane_skew)
   );

   always #5 read_clk = ~read_clk;

   int checks = 0;
   int passes = 0;
   int beat;
   int base;
   int off [NL];
   int slip_lane;
   int slip_from;
   int err_cnt;
   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic skew_t pk(input int a0, input int a1, input int a2, input int a3);
      skew_t r;
      r[0] = SW'(a0);
      r[1] = SW'(a1);
      r[2] = SW'(a2);
      r[3] = SW'(a3);
      return r;
   endfunction

   // Lane l symbol at valid beat b: COM every PERIOD beats from base+off[l], else a tagged non-COM word.
   function automatic logic [DW-1:0] lane_sym(input int l, input int b);
      int rel;
      rel = b - base - off[l];
      if (l == slip_lane && b >= slip_from) rel = rel - 1;
      if (b >= 0 && rel >= 0 && (rel % PERIOD) == 0) return (l % 2 == 1) ? COM_N : COM_P;
      return DW'(32'h100 | (l << 6) | (b & 63));
   endfunction

   // Output after consuming beat (beat-1) is the lane symbol from beat-2-delay.
   function automatic logic [NL*DW-1:0] exp_out(input skew_t d);
      logic [NL*DW-1:0] e;
      for (int l = 0; l < NL; l++) e[l*DW +: DW] = lane_sym(l, beat - 2 - int'(d[l]));
      return e;
   endfunction

   task automatic drive(input logic v);
      in_valid = v;
      for (int l = 0; l < NL; l++) data_in[l*DW +: DW] = v ? lane_sym(l, beat) : ((l % 2 == 1) ? COM_N : COM_P);
      @(posedge read_clk);
      #1;
      if (v) beat++;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_valid = 1'b0;
      data_in  = '0;
      @(posedge read_clk);
      #1;
      rst_n     = 1'b1;
      beat      = 0;
      base      = 1000;
      slip_lane = -1;
      slip_from = 0;
   endtask

   // Lock on a COM set with the given per-lane offsets, then verify aligned output beats.
   task automatic lock_seq(input skew_t o, input int gap, input skew_t s, input string tag);
      int mx;
      int gapped;
      mx = 0;
      for (int l = 0; l < NL; l++) begin
         off[l] = int'(o[l]);
         if (off[l] > mx) mx = off[l];
      end
      base   = beat + 3;
      gapped = 0;
      while (beat < base + mx) begin
         if (gap > 0 && gapped == 0 && beat == base + 1) begin
            repeat (gap) drive(1'b0);
            gapped = 1;
            check({tag, "_stall_no_out"}, {aligned, out_valid, deskew_error}, 3'b000);
         end
         drive(1'b1);
      end
      check({tag, "_pre_lock"}, aligned, 1'b0);
      drive(1'b1);
      check({tag, "_lock"}, {aligned, out_valid, deskew_error, lane_skew}, {3'b100, s});
      for (int n = 0; n < 8; n++) begin
         drive(1'b1);
         if (n == 0) check({tag, "_coms_together"}, data_out, ALL_COM);
         check({tag, "_beat"}, {out_valid, deskew_error, data_out}, {2'b10, exp_out(s)});
      end
      drive(1'b0);
      check({tag, "_stall_hold"}, {out_valid, aligned, data_out}, {2'b01, exp_out(s)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{off: pk(0, 1, 3, 2), gap: 0, skew: pk(3, 2, 0, 1)};
      vecs[1] = '{off: pk(0, 0, 0, 0), gap: 0, skew: pk(0, 0, 0, 0)};
      vecs[2] = '{off: pk(0, 1, 3, 2), gap: 3, skew: pk(3, 2, 0, 1)};
      vecs[3] = '{off: pk(4, 0, 2, 1), gap: 0, skew: pk(0, 4, 2, 3)};
      vecs[4] = '{off: pk(2, 2, 0, 0), gap: 0, skew: pk(0, 0, 2, 2)};

      do_reset();
      check("reset_state", {data_out, out_valid, aligned, deskew_error, lane_skew}, '0);

      for (int v = 0; v < 5; v++) begin
         do_reset();
         lock_seq(vecs[v].off, vecs[v].gap, vecs[v].skew, $sformatf("vec%0d", v));
      end

      // Lane 3 COM five beats late: window times out at cnt=4, then a fresh window from lane 3 times out too.
      do_reset();
      off[0] = 0; off[1] = 0; off[2] = 0; off[3] = 5;
      base = beat + 3;
      while (beat < base + 4) drive(1'b1);
      check("timeout_quiet", {deskew_error, aligned}, 2'b00);
      drive(1'b1);
      check("timeout_pulse", {deskew_error, aligned, out_valid}, 3'b100);
      drive(1'b1);
      check("timeout_pulse_end", deskew_error, 1'b0);
      while (beat < base + 9) drive(1'b1);
      drive(1'b1);
      check("timeout_second", {deskew_error, aligned}, 2'b10);
      lock_seq(pk(0, 1, 1, 0), 0, pk(1, 0, 0, 1), "after_timeout");

      // Lane 2 slips one symbol after lock.
      do_reset();
      lock_seq(pk(0, 1, 3, 2), 0, pk(3, 2, 0, 1), "slip");
      slip_lane = 2;
      slip_from = beat;
      err_cnt   = 0;
      while (beat < base + 20) begin
         drive(1'b1);
         err_cnt += int'(deskew_error);
      end
      check("slip_quiet", err_cnt, 0);
      drive(1'b1);
      check("slip_error", {deskew_error, aligned, out_valid}, 3'b100);
      drive(1'b1);
      check("slip_error_end", deskew_error, 1'b0);
`ifdef DESKEW_AUTO_REALIGN_EN
      while (beat < base + 36) drive(1'b1);
      check("realign_pre_lock", {aligned, lane_skew}, {1'b0, pk(3, 2, 0, 1)});
      drive(1'b1);
      check("realign_lock", {aligned, deskew_error, lane_skew}, {2'b10, pk(4, 3, 0, 2)});
      drive(1'b1);
      check("realign_coms_together", {out_valid, data_out}, {1'b1, ALL_COM});
`else
      err_cnt = 0;
      repeat (24) begin
         drive(1'b1);
         err_cnt += int'(deskew_error);
      end
      check("lock_err_single_pulse", err_cnt, 0);
      check("lock_err_stuck", {aligned, out_valid, lane_skew}, {2'b00, pk(3, 2, 0, 1)});
`endif

      // Asynchronous reset while locked, then restart.
      do_reset();
      lock_seq(pk(0, 1, 3, 2), 0, pk(3, 2, 0, 1), "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", {data_out, out_valid, aligned, deskew_error, lane_skew}, '0);
      do_reset();
      check("reset_release", {data_out, out_valid, aligned, deskew_error, lane_skew}, '0);
      lock_seq(pk(2, 2, 0, 0), 0, pk(0, 0, 2, 2), "post_rst");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
